// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// FSM state type and the request legality/alignment check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // True when the request must be answered with resp_misaligned instead of a
  // memory access: unknown funct3 for its direction, or a misaligned address.
  function automatic logic lsu_req_err(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    if (we) legal = funct3 inside {F3_B, F3_H, F3_W};
    else    legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data aligner: picks the addressed byte/halfword lane of a little-endian
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    // NOTE: every output gets a value on every path, otherwise a latch is inferred.
    data_o  = '0;
    shifted = word_i >> {addr_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:    data_o = word_i;
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Load/store unit between EX/MEM and a word-write dmem. Sub-word stores are
// done as read-modify-write; loads return extended data with a misalign flag.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [XLEN-1:0]    req_addr,
  input  logic [XLEN-1:0]    req_wdata,
  output logic               resp_valid,
  output logic [XLEN-1:0]    resp_rdata,
  output logic               resp_misaligned,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_a,
  output logic [XLEN-1:0]    dmem_wd,
  input  logic [XLEN-1:0]    dmem_rd
);

  lsu_state_t         state_q;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [DMEM_AW-1:0] addr_q;
  logic [XLEN-1:0]    wdata_q;
  logic [XLEN-1:0]    merge_q;
  logic [XLEN-1:0]    resp_rdata_q;
  logic               resp_mis_q;

  logic               accept;
  logic               req_err;
  logic [XLEN-1:0]    load_data;
  logic [XLEN-1:0]    wd_d;

  // Address bits above the dmem window are deliberately ignored (wrap-around).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[XLEN-1:DMEM_AW];

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign req_err   = lsu_req_err(req_we, req_funct3, req_addr[1:0]);

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .word_i   (dmem_rd),
    .addr_i   (addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  // Store word: the old word with the addressed lane replaced, or the full word for SW.
  always_comb begin
    wd_d = merge_q;
    case (funct3_q)
      F3_B:    wd_d[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      F3_H:    wd_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: wd_d = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[DMEM_AW-1:0];
            wdata_q  <= req_wdata;
            if (req_err) begin
              resp_rdata_q <= '0;
              resp_mis_q   <= 1'b1;
              state_q      <= RESP;
            end else if (req_we && (req_funct3 == F3_W)) begin
              state_q <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (we_q) begin
            merge_q <= dmem_rd;
            state_q <= WRITE;
          end else begin
            resp_rdata_q <= load_data;
            resp_mis_q   <= 1'b0;
            state_q      <= RESP;
          end
        end
        WRITE: begin
          resp_rdata_q <= '0;
          resp_mis_q   <= 1'b0;
          state_q      <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid      = (state_q == RESP);
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;

  // Write enable is cut combinationally by reset so an in-flight RMW never lands.
  assign dmem_we = (state_q == WRITE) && !reset;
  assign dmem_a  = ((state_q == READ) || (state_q == WRITE)) ? addr_q : '0;
  assign dmem_wd = (state_q == WRITE) ? wd_d : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: transaction-level model with expected
// response/write schedules, directed scenarios plus randomized traffic.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        dmem_we;
  logic [7:0]  dmem_a;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .DMEM_AW(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .dmem_we         (dmem_we),
    .dmem_a          (dmem_a),
    .dmem_wd         (dmem_wd),
    .dmem_rd         (dmem_rd)
  );

  logic [31:0] dmem    [64];
  logic [31:0] ref_mem [64];
  logic        mem_init = 1'b1;

  assign dmem_rd = dmem[dmem_a[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) dmem[i] <= ref_mem[i];
    end else if (dmem_we) begin
      dmem[dmem_a[7:2]] <= dmem_wd;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int due; logic [31:0] rdata; logic mis; } resp_t;
  typedef struct { int due; logic [7:0] a; logic [31:0] wd; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  int    busy_until = -1;
  bit    after_rst = 1'b0;
  int    last_acc = 0, last_resp_cyc = 0, last_we_cyc = -1, resp_count = 0;
  logic [31:0] last_rdata = '0;
  logic        last_mis = 1'b0;
  int    resp_cycles[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference rules, written from the architectural description of each access.
  function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int size;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    return !legal || ((a % size) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [31:0] a);
    logic [31:0] v;
    v = w >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      3'd2: v = w;
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int          off;
    if (f3 == 3'd2) return wd;
    off  = 8 * (a % 4);
    mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
    return (old & ~(mask << off)) | ((wd & mask) << off);
  endfunction

  task automatic compare_loop();
    bit    exp_rv, exp_we, err;
    int    lat;
    resp_t r;
    wr_t   w;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_dmem_we", dmem_we, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        rq.delete();
        wq.delete();
        busy_until = cyc;
        after_rst  = 1'b1;
      end else begin
        if (after_rst) begin
          check("post_rst_rdata", resp_rdata, 32'h0);
          check("post_rst_mis", resp_misaligned, 1'b0);
          after_rst = 1'b0;
        end
        exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
        check("resp_valid", resp_valid, exp_rv);
        if (resp_valid) begin
          last_resp_cyc = cyc;
          last_rdata    = resp_rdata;
          last_mis      = resp_misaligned;
          resp_count++;
          resp_cycles.push_back(cyc);
        end
        if (exp_rv) begin
          check("resp_rdata", resp_rdata, rq[0].rdata);
          check("resp_misaligned", resp_misaligned, rq[0].mis);
          void'(rq.pop_front());
        end
        exp_we = (wq.size() > 0) && (wq[0].due == cyc);
        check("dmem_we", dmem_we, exp_we);
        if (dmem_we) last_we_cyc = cyc;
        if (exp_we) begin
          check("dmem_a", dmem_a, wq[0].a);
          check("dmem_wd", dmem_wd, wq[0].wd);
          ref_mem[wq[0].a[7:2]] = wq[0].wd;
          void'(wq.pop_front());
        end
        check("req_ready", req_ready, cyc > busy_until);
        if (cyc > busy_until) begin
          check("idle_dmem_a", dmem_a, 8'h00);
          if (req_valid) begin
            err = m_err(req_we, req_funct3, req_addr);
            lat = err ? 1 : ((req_we && req_funct3 != 3'd2) ? 3 : 2);
            last_acc   = cyc;
            busy_until = cyc + lat;
            r.due   = cyc + lat;
            r.mis   = err;
            r.rdata = (err || req_we) ? 32'h0 : m_load(ref_mem[req_addr[7:2]], req_funct3, req_addr);
            rq.push_back(r);
            if (!err && req_we) begin
              w.due = cyc + lat - 1;
              w.a   = req_addr[7:0];
              w.wd  = m_store(ref_mem[req_addr[7:2]], req_funct3, req_addr, req_wdata);
              wq.push_back(w);
            end
          end
        end
      end
    end
  endtask

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    int n0;
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) check("accept_timeout", req_ready, 1'b1);
    @(posedge clk);
    n0 = resp_count;
    #1 req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk);
      ok = (resp_count > n0);
    end
    if (!ok) check("resp_timeout", resp_count, n0 + 1);
  endtask

  initial begin
    int n, base;
    bit ok;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[4]  = 32'h8899_AABB;
    ref_mem[12] = 32'h1122_3344;
    ref_mem[16] = 32'h5566_7788;
    fork
      compare_loop();
    join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mem_init = 1'b0;

    // Sign- and zero-extended byte loads.
    do_req(1'b0, 3'b000, 32'h11, 32'h0);
    check("lb_rdata", last_rdata, 32'hFFFF_FFAA);
    check("lb_mis", last_mis, 1'b0);
    check("lb_latency", last_resp_cyc - last_acc, 2);
    do_req(1'b0, 3'b100, 32'h11, 32'h0);
    check("lbu_rdata", last_rdata, 32'h0000_00AA);

    // Word store then load back.
    do_req(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
    check("sw_latency", last_resp_cyc - last_acc, 2);
    check("sw_we_cycle", last_we_cyc - last_acc, 1);
    check("sw_mem", dmem[8], 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    check("lw_rdata", last_rdata, 32'hDEAD_BEEF);

    // Halfword read-modify-write into the upper lane.
    do_req(1'b1, 3'b001, 32'h32, 32'h0000_CAFE);
    check("sh_latency", last_resp_cyc - last_acc, 3);
    check("sh_we_cycle", last_we_cyc - last_acc, 2);
    check("sh_mem", dmem[12], 32'hCAFE_3344);
    do_req(1'b0, 3'b101, 32'h32, 32'h0);
    check("lhu_rdata", last_rdata, 32'h0000_CAFE);
    do_req(1'b0, 3'b001, 32'h32, 32'h0);
    check("lh_rdata", last_rdata, 32'hFFFF_CAFE);

    // Error responses.
    do_req(1'b0, 3'b010, 32'h22, 32'h0);
    check("lw_mis_flag", last_mis, 1'b1);
    check("lw_mis_rdata", last_rdata, 32'h0);
    check("lw_mis_latency", last_resp_cyc - last_acc, 1);
    do_req(1'b1, 3'b001, 32'h21, 32'h1234);
    check("sh_mis_flag", last_mis, 1'b1);
    do_req(1'b0, 3'b011, 32'h20, 32'h0);
    check("ld011_flag", last_mis, 1'b1);

    // Reset during the WRITE cycle of an SB abandons the store.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h41; req_wdata = 32'h99;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) check("sb_accept_timeout", req_ready, 1'b1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rst_in_write_we", dmem_we, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("sb_abandoned_mem", dmem[16], 32'h5566_7788);

    // Three SWs with req_valid held high.
    base = resp_cycles.size();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h50; req_wdata = $urandom;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (req_ready) begin
        n++;
        @(posedge clk); #1;
        if (n == 3) req_valid = 1'b0;
        else begin
          req_addr  = req_addr + 32'h4;
          req_wdata = $urandom;
        end
      end
    end
    check("b2b_accepts", n, 3);
    for (int i = 0; i < 20 && resp_cycles.size() < base + 3; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("b2b_pulses", resp_cycles.size() - base, 3);
    if (resp_cycles.size() >= base + 3) begin
      check("b2b_gap1", resp_cycles[base+1] - resp_cycles[base], 3);
      check("b2b_gap2", resp_cycles[base+2] - resp_cycles[base+1], 3);
    end

    // Randomized traffic, including wrapped high address bits and illegal funct3.
    for (int t = 0; t < 250; t++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << f3[1:0]) - 32'h1);
      do_req(1'($urandom_range(0, 1)), f3, a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    for (int i = 0; i < 64; i++) check("final_mem", dmem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
